roll_controller: RTL and testbench
==================================

# roll_controller

Turn-based roll sequencer for the two-player dice game. It arbitrates the shared LED bar and die register between two player buttons. For the player whose turn it is, it runs a hold-to-fill bar animation and samples a die value when the bar is full. It shows the result, accumulates per-player scores and then passes the turn. It sits between the raw board buttons and the LED/seven-segment display drivers.

## Interface
- N, 10, LED bar width (≥2)
- STEP_DIV, 5_000_000, clock cycles per bar step (≥1)
- SHOW_CYC, 50_000_000, cycles the result is held (≥1)
- FACES, 6, die faces (2..7)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_p1  in  1  player 1 button, raw, active-high
- btn_p2  in  1  player 2 button, raw, active-high
- led  out  N  bar; led[0] lights first
- bar_full  out  1  high while led is all ones
- die  out  3  last rolled value 1..FACES; 0 before first roll
- die_valid  out  1  one-cycle pulse when die updates
- turn  out  1  0 = player 1, 1 = player 2
- busy  out  1  high in any state except IDLE
- score_p1, score_p2  out  7 each  accumulated scores, saturate at 99

## Operation
- Buttons pass through a 2-flop synchronizer. The FSM acts on the synchronized level only. Debounce is handled off-block.
- Arbitration:
  - Only the button selected by turn is examined.
  - The other button is ignored in every state, including during simultaneous presses.
- States: IDLE, FILL, ROLL, SHOW, RELEASE.
- IDLE:
  - led = 0.
  - Active button high → FILL; step counter cleared.
- FILL:
  - Step counter counts 0..STEP_DIV-1. On wrap, led <= {led[N-2:0],1'b1}.
  - Active button low before the bar is full → IDLE. led clears; no roll; turn unchanged.
  - Bar full (N steps) → ROLL.
- ROLL (1 cycle):
  - die <= face_cnt + 1.
  - Active player's score <= min(score + die, 99).
  - → SHOW.
- SHOW:
  - led held all ones; counts SHOW_CYC cycles, then → RELEASE.
  - Button state is ignored.
- RELEASE:
  - Waits for the active button to be low; led clears.
  - On exit: turn toggles, → IDLE.
- face_cnt:
  - Free-running 0..FACES-1, increments every cycle in all states, wraps to 0.
  - Reset value 0.
- Score arithmetic: 8-bit sum, then clamp to 99.

## Timing
- Reset values (asynchronous, applied while reset_n = 0):
  - Outputs: led 0, bar_full 0, die 0, die_valid 0, turn 0, busy 0, scores 0.
  - Internals: state IDLE, face_cnt 0, synchronizers 0.
- Input latency: a pin change is visible to the FSM 2 cycles later.
- FILL entry to bar full: exactly N×STEP_DIV cycles. bar_full rises in the cycle ROLL is entered.
- die, score and die_valid update on the clock edge leaving ROLL:
  - die_valid is high for exactly the first SHOW cycle.
  - Scores are visible in the same cycle.
- busy is registered from state; it is high from the cycle after the FILL transition.
- Abort from FILL: led is 0 on the cycle after the synchronized release is seen.
- Mid-operation reset: any state returns to IDLE immediately. Scores and turn are lost.

## Structure
- Package roll_pkg:
  - state_t enum (IDLE, FILL, ROLL, SHOW, RELEASE).
  - player_t (P1 = 0, P2 = 1).
  - SCORE_MAX = 99.
- Sub-module btn_sync: 2-flop synchronizer with async active-low reset, instantiated once per button.
- FSM, step counter, bar shift, face counter and score registers live in roll_controller.

## Test plan
Bench parameters: N=4, STEP_DIV=2, SHOW_CYC=3, FACES=6.

- Reset check: hold reset_n low mid-FILL → all outputs at reset values within the same cycle; state IDLE after release.
- Full roll for P1:
  - Stimulus: press btn_p1 at cycle 10 after reset release and hold.
  - Response: FILL seen at cycle 12; led steps 0001, 0011, 0111, 1111 every 2 cycles.
  - ROLL: die = (face_cnt at ROLL) + 1; die_valid is a single pulse; score_p1 = die.
  - Release: turn = 1.
- Early release: press btn_p1 for 4 cycles → led returns to 0; die_valid never pulses; turn stays 0.
- Wrong player / simultaneous press:
  - btn_p2 held alone while turn = 0 → busy stays 0.
  - Both buttons pressed together → only P1 rolls.
- Saturation: preload score_p1 = 97 via repeated rolls, then roll a 5 → score_p1 = 99.
- Held through SHOW: keep btn_p1 high after SHOW → FSM stays in RELEASE, turn unchanged until release, then toggles once.

Source files
------------

// File: rtl/roll_pkg.sv
// roll_pkg: shared types and score arithmetic for the roll sequencer.
//   state_t  - sequencer states (IDLE, FILL, ROLL, SHOW, RELEASE)
//   player_t - whose turn it is (P1 = 0, P2 = 1)
//   SCORE_MAX, sat_add - saturating score accumulation
package roll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ROLL,
        SHOW,
        RELEASE
    } state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    localparam int unsigned SCORE_MAX = 99;

    // 8-bit sum so a score near the limit cannot wrap before the clamp.
    function automatic logic [6:0] sat_add(input logic [6:0] score, input logic [2:0] pips);
        logic [7:0] sum;
        sum = {1'b0, score} + {5'b0, pips};
        return (sum > 8'(SCORE_MAX)) ? 7'(SCORE_MAX) : sum[6:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for one raw button input.
//   clk     - system clock
//   reset_n - asynchronous active-low reset, clears both flops
//   din     - raw asynchronous level
//   dout    - synchronized level, two clocks behind din
module btn_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/roll_controller.sv
// roll_controller: turn-based roll sequencer for the two-player dice game.
// The player whose turn it is holds a button to fill the LED bar; a full
// bar samples the free-running face counter as the die value, adds it to
// that player's score, shows the result and hands the turn over once the
// button is released.
//   clk                - system clock
//   reset_n            - asynchronous active-low reset
//   btn_p1, btn_p2     - raw active-high player buttons
//   led[N-1:0]         - bar display, led[0] lights first
//   bar_full           - high while led is all ones
//   die[2:0]           - last rolled value 1..FACES, 0 before first roll
//   die_valid          - one-cycle pulse in the first SHOW cycle
//   turn               - 0 = player 1, 1 = player 2
//   busy               - high whenever the sequencer is not idle
//   score_p1, score_p2 - accumulated scores, saturating at 99
module roll_controller
    import roll_pkg::*;
#(
    parameter int unsigned N        = 10,
    parameter int unsigned STEP_DIV = 5_000_000,
    parameter int unsigned SHOW_CYC = 50_000_000,
    parameter int unsigned FACES    = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         btn_p1,
    input  logic         btn_p2,
    output logic [N-1:0] led,
    output logic         bar_full,
    output logic [2:0]   die,
    output logic         die_valid,
    output logic         turn,
    output logic         busy,
    output logic [6:0]   score_p1,
    output logic [6:0]   score_p2
);

    localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SHOW_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
    localparam logic [2:0]        FACE_LAST = 3'(FACES - 1);

    state_t            state;
    player_t           cur;
    logic              p1_s;
    logic              p2_s;
    logic              act;
    logic [STEP_W-1:0] step_cnt;
    logic [SHOW_W-1:0] show_cnt;
    logic [2:0]        face_cnt;
    logic [2:0]        pips;

    btn_sync u_sync_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (btn_p1),
        .dout    (p1_s)
    );

    btn_sync u_sync_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (btn_p2),
        .dout    (p2_s)
    );

    // Only the button of the player on turn is ever looked at.
    always_comb begin
        act  = (cur == P1) ? p1_s : p2_s;
        pips = face_cnt + 3'd1;
    end

    assign turn = cur;

    // Free-running face counter; the roll samples it, so its phase relative
    // to the button press is what makes the outcome unpredictable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            face_cnt <= '0;
        end else if (face_cnt == FACE_LAST) begin
            face_cnt <= '0;
        end else begin
            face_cnt <= face_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur       <= P1;
            led       <= '0;
            bar_full  <= 1'b0;
            die       <= '0;
            die_valid <= 1'b0;
            busy      <= 1'b0;
            score_p1  <= '0;
            score_p2  <= '0;
            step_cnt  <= '0;
            show_cnt  <= '0;
        end else begin
            die_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (act) begin
                        state    <= FILL;
                        busy     <= 1'b1;
                        step_cnt <= '0;
                        led      <= '0;
                    end
                end
                FILL: begin
                    if (!act) begin
                        // Released before the bar filled: abandon the roll.
                        state <= IDLE;
                        busy  <= 1'b0;
                        led   <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        led      <= {led[N-2:0], 1'b1};
                        // The shift that lights the top LED completes the bar.
                        if (&led[N-2:0]) begin
                            state    <= ROLL;
                            bar_full <= 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ROLL: begin
                    die       <= pips;
                    die_valid <= 1'b1;
                    if (cur == P1) begin
                        score_p1 <= sat_add(score_p1, pips);
                    end else begin
                        score_p2 <= sat_add(score_p2, pips);
                    end
                    show_cnt <= '0;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (show_cnt == SHOW_LAST) begin
                        state    <= RELEASE;
                        led      <= '0;
                        bar_full <= 1'b0;
                    end else begin
                        show_cnt <= show_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!act) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cur   <= (cur == P1) ? P2 : P1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    led   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roll_controller.sv
// tb_roll_controller: self-checking bench for roll_controller.
// A behavioural model tracks the game in terms of elapsed cycles per phase
// and compares every DUT output once per clock, on the falling edge.
module tb_roll_controller;

    localparam int N        = 4;
    localparam int STEP_DIV = 2;
    localparam int SHOW_CYC = 3;
    localparam int FACES    = 6;
    localparam int ALL_ON   = (1 << N) - 1;

    localparam int PH_IDLE = 0;
    localparam int PH_FILL = 1;
    localparam int PH_ROLL = 2;
    localparam int PH_SHOW = 3;
    localparam int PH_REL  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         btn_p1 = 1'b0;
    logic         btn_p2 = 1'b0;
    logic [N-1:0] led;
    logic         bar_full;
    logic [2:0]   die;
    logic         die_valid;
    logic         turn;
    logic         busy;
    logic [6:0]   score_p1;
    logic [6:0]   score_p2;

    always #5 clk = ~clk;

    roll_controller #(
        .N        (N),
        .STEP_DIV (STEP_DIV),
        .SHOW_CYC (SHOW_CYC),
        .FACES    (FACES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_p1    (btn_p1),
        .btn_p2    (btn_p2),
        .led       (led),
        .bar_full  (bar_full),
        .die       (die),
        .die_valid (die_valid),
        .turn      (turn),
        .busy      (busy),
        .score_p1  (score_p1),
        .score_p2  (score_p2)
    );

    int checks = 0;
    int fails  = 0;
    int dv_seen = 0;

    // Model state
    int m_ph;
    int fill_t;
    int show_t;
    int ticks;
    int m_turn;
    int m_die;
    bit m_dv;
    int sc[2];
    bit sy1[2];
    bit sy2[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_led();
        case (m_ph)
            PH_FILL: return (1 << (fill_t / STEP_DIV)) - 1;
            PH_ROLL, PH_SHOW: return ALL_ON;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = PH_IDLE;
        fill_t = 0;
        show_t = 0;
        ticks  = 0;
        m_turn = 0;
        m_die  = 0;
        m_dv   = 1'b0;
        sc[0]  = 0;
        sc[1]  = 0;
        sy1[0] = 1'b0;
        sy1[1] = 1'b0;
        sy2[0] = 1'b0;
        sy2[1] = 1'b0;
    endtask

    // One clock edge of the game rules, using pre-edge values.
    task automatic model_step(input bit b1, input bit b2);
        bit act;
        int face;
        act  = sy2[m_turn];
        face = ticks % FACES;
        ticks++;
        m_dv = 1'b0;
        case (m_ph)
            PH_IDLE: if (act) begin
                m_ph   = PH_FILL;
                fill_t = 0;
            end
            PH_FILL: begin
                if (!act) begin
                    m_ph = PH_IDLE;
                end else begin
                    fill_t++;
                    if (fill_t == N * STEP_DIV) m_ph = PH_ROLL;
                end
            end
            PH_ROLL: begin
                m_die = face + 1;
                sc[m_turn] = (sc[m_turn] + m_die > 99) ? 99 : sc[m_turn] + m_die;
                m_dv   = 1'b1;
                m_ph   = PH_SHOW;
                show_t = 0;
            end
            PH_SHOW: begin
                show_t++;
                if (show_t == SHOW_CYC) m_ph = PH_REL;
            end
            PH_REL: if (!act) begin
                m_turn = 1 - m_turn;
                m_ph   = PH_IDLE;
            end
            default: m_ph = PH_IDLE;
        endcase
        sy2[0] = sy1[0];
        sy2[1] = sy1[1];
        sy1[0] = b1;
        sy1[1] = b2;
    endtask

    task automatic check_outputs();
        check("led", 32'(led), 32'(exp_led()));
        check("bar_full", 32'(bar_full), 32'(exp_led() == ALL_ON));
        check("die", 32'(die), 32'(m_die));
        check("die_valid", 32'(die_valid), 32'(m_dv));
        check("turn", 32'(turn), 32'(m_turn));
        check("busy", 32'(busy), 32'(m_ph != PH_IDLE));
        check("score_p1", 32'(score_p1), 32'(sc[0]));
        check("score_p2", 32'(score_p2), 32'(sc[1]));
    endtask

    // Called just after a falling edge: drive, clock, then compare.
    task automatic cycle(input bit b1, input bit b2);
        btn_p1 = b1;
        btn_p2 = b2;
        @(posedge clk);
        if (reset_n) model_step(b1, b2);
        else model_reset();
        @(negedge clk);
        if (die_valid === 1'b1) dv_seen++;
        check_outputs();
    endtask

    task automatic cycles(input bit b1, input bit b2, input int n);
        for (int i = 0; i < n; i++) cycle(b1, b2);
    endtask

    // Drive the button of the player the model says is on turn.
    task automatic owner_cycle(input bit own, input bit other);
        if (m_turn == 0) cycle(own, other);
        else cycle(other, own);
    endtask

    initial begin
        int dv_before;
        int sc2_before;
        int iter;
        int dur;

        model_reset();
        @(negedge clk);
        cycles(1'b0, 1'b0, 3);
        reset_n = 1'b1;

        // Full roll for player 1, button held well into RELEASE.
        cycles(1'b0, 1'b0, 10);
        dv_before = dv_seen;
        cycles(1'b1, 1'b0, 2 + N * STEP_DIV + 1 + SHOW_CYC + 5);
        check("held_turn", 32'(turn), 32'd0);
        check("held_busy", 32'(busy), 32'd1);
        cycles(1'b0, 1'b0, 4);
        check("p1_turn_passed", 32'(turn), 32'd1);
        check("p1_one_pulse", 32'(dv_seen - dv_before), 32'd1);
        check("p1_score_eq_die", 32'(score_p1), 32'(m_die));

        // P1 pressing while it is P2's turn, then a P2 roll hands back.
        cycles(1'b1, 1'b0, 20);
        check("p1_ignored", 32'(busy), 32'd0);
        cycles(1'b0, 1'b0, 2);
        cycles(1'b0, 1'b1, 2 + N * STEP_DIV + 1 + SHOW_CYC + 1);
        cycles(1'b0, 1'b0, 4);
        check("p2_turn_passed", 32'(turn), 32'd0);

        // P2 held alone while P1 is on turn.
        cycles(1'b0, 1'b1, 20);
        check("p2_ignored", 32'(busy), 32'd0);
        cycles(1'b0, 1'b0, 2);

        // Early release from FILL.
        dv_before = dv_seen;
        cycles(1'b1, 1'b0, 4);
        cycles(1'b0, 1'b0, 6);
        check("abort_led", 32'(led), 32'd0);
        check("abort_no_pulse", 32'(dv_seen - dv_before), 32'd0);
        check("abort_turn", 32'(turn), 32'd0);

        // Simultaneous press: only P1 rolls.
        sc2_before = sc[1];
        dv_before  = dv_seen;
        cycles(1'b1, 1'b1, 2 + N * STEP_DIV + 1 + SHOW_CYC + 2);
        cycles(1'b0, 1'b0, 4);
        check("both_p2_score", 32'(score_p2), 32'(sc2_before));
        check("both_one_pulse", 32'(dv_seen - dv_before), 32'd1);
        check("both_turn", 32'(turn), 32'd1);

        // Reset asserted in the middle of FILL.
        cycles(1'b0, 1'b1, 6);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_scores", 32'({score_p1, score_p2}), 32'd0);
        check_outputs();
        @(negedge clk);
        cycles(1'b0, 1'b1, 2);
        reset_n = 1'b1;
        cycles(1'b0, 1'b0, 4);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Random play until player 1 saturates.
        iter = 0;
        while (sc[0] < 99 && iter < 300) begin
            iter++;
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(12, 30);
            for (int i = 0; i < dur; i++) owner_cycle(1'b1, $urandom_range(0, 4) == 0);
            dur = $urandom_range(1, 4);
            for (int i = 0; i < dur; i++) owner_cycle(1'b0, $urandom_range(0, 4) == 0);
        end
        check("sat_p1", 32'(score_p1), 32'd99);
        cycles(1'b0, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
